wb_stage: RTL

//  Writeback stage, directly downstream of the memory stage. Registers the memory

---
 rtl/wb_stage_if.sv | 40 ++++
 rtl/wb_stage.sv | 108 ++++++++++
 2 files changed

// File: rtl/wb_stage_if.sv
// Memory-stage to writeback-stage bundle: pipeline inputs into WB and the
// register-file write, forwarding and status outputs coming back out.
interface wb_stage_if #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3,
    parameter int CNT_W  = 16
);
    logic [DATA_W-1:0] MemOut;
    logic [DATA_W-1:0] ALUout;
    logic [DATA_W-1:0] PCinc;
    logic [DATA_W-1:0] ImmIn;
    logic [1:0]        WbSel;
    logic              RegWrt;
    logic [REG_AW-1:0] WrReg;
    logic              HaltIn;
    logic              ValidIn;
    logic              MemStall;
    logic              Flush;
    logic [DATA_W-1:0] WrData;
    logic [REG_AW-1:0] WrRegOut;
    logic              RegWrtOut;
    logic              FwdValid;
    logic              HaltOut;
    logic [CNT_W-1:0]  RetireCnt;

    // Handshake: there is no backpressure out of WB. An instruction is offered
    // when ValidIn=1 and is taken on the rising edge unless Flush, MemStall or a
    // halt blocks it, in which case a bubble enters WB instead.
    modport master (
        output MemOut, ALUout, PCinc, ImmIn, WbSel, RegWrt, WrReg,
        output HaltIn, ValidIn, MemStall, Flush,
        input  WrData, WrRegOut, RegWrtOut, FwdValid, HaltOut, RetireCnt
    );

    modport slave (
        input  MemOut, ALUout, PCinc, ImmIn, WbSel, RegWrt, WrReg,
        input  HaltIn, ValidIn, MemStall, Flush,
        output WrData, WrRegOut, RegWrtOut, FwdValid, HaltOut, RetireCnt
    );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB pipeline register, write-value select, register-file
// write/forwarding, sticky halt FSM and retired-instruction counter.
module wb_stage #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3,
    parameter int CNT_W  = 16
) (
    input  logic       clk,
    input  logic       rst,
    wb_stage_if.slave  wb,
    output logic       o_dbg_state
);
    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t            r_state;
    logic              r_valid;
    logic [DATA_W-1:0] r_mem;
    logic [DATA_W-1:0] r_alu;
    logic [DATA_W-1:0] r_pcinc;
    logic [DATA_W-1:0] r_imm;
    logic [1:0]        r_wbsel;
    logic              r_regwrt;
    logic [REG_AW-1:0] r_wrreg;
    logic              r_halt;
    logic [CNT_W-1:0]  r_retire_cnt;

    logic              w_halt_resident;
    logic              w_halted;
    logic              w_capture;
    logic [DATA_W-1:0] w_wr_data;

    assign w_halt_resident = r_valid & r_halt;
    // Treat the machine as halted from the cycle the HALT sits in WB, so the
    // instruction behind it never enters WB and never writes.
    assign w_halted  = (r_state == ST_HALTED) | w_halt_resident;
    assign w_capture = ~w_halted & ~wb.Flush & ~wb.MemStall & wb.ValidIn;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_RUN;
            r_valid      <= 1'b0;
            r_mem        <= '0;
            r_alu        <= '0;
            r_pcinc      <= '0;
            r_imm        <= '0;
            r_wbsel      <= 2'b00;
            r_regwrt     <= 1'b0;
            r_wrreg      <= '0;
            r_halt       <= 1'b0;
            r_retire_cnt <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (r_valid) begin
                        r_retire_cnt <= r_retire_cnt + CNT_W'(1);
                    end
                    if (w_halt_resident) begin
                        r_state <= ST_HALTED;
                    end
                end
                ST_HALTED: r_state <= ST_HALTED;
                default:   r_state <= ST_RUN;
            endcase

            if (w_capture) begin
                r_valid  <= 1'b1;
                r_mem    <= wb.MemOut;
                r_alu    <= wb.ALUout;
                r_pcinc  <= wb.PCinc;
                r_imm    <= wb.ImmIn;
                r_wbsel  <= wb.WbSel;
                r_regwrt <= wb.RegWrt;
                r_wrreg  <= wb.WrReg;
                r_halt   <= wb.HaltIn;
            end else begin
                // Bubble: control cleared, operands held to avoid needless toggling.
                r_valid  <= 1'b0;
                r_wbsel  <= 2'b00;
                r_regwrt <= 1'b0;
                r_wrreg  <= '0;
                r_halt   <= 1'b0;
            end
        end
    end

    always_comb begin
        w_wr_data = r_alu;
        case (r_wbsel)
            2'b00:   w_wr_data = r_alu;
            2'b01:   w_wr_data = r_mem;
            2'b10:   w_wr_data = r_pcinc;
            2'b11:   w_wr_data = r_imm;
            default: w_wr_data = r_alu;
        endcase
    end

    assign wb.WrData    = w_wr_data;
    assign wb.WrRegOut  = r_wrreg;
    assign wb.RegWrtOut = r_valid & r_regwrt & ~r_halt;
    assign wb.FwdValid  = r_valid & r_regwrt & ~r_halt;
    assign wb.HaltOut   = (r_state == ST_HALTED) | w_halt_resident;
    assign wb.RetireCnt = r_retire_cnt;
    assign o_dbg_state  = (r_state == ST_HALTED);

endmodule
